// File: rtl/sub_40b_seq.sv
// Sequential WIDTH-bit subtractor: D = A - B - Bin computed one SLICE-bit
// add slice per clock, with B inverted and the borrow carried as inverted carry.
module sub_40b_seq #(
  parameter int WIDTH = 40,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] res_next;

  // One shared slice adder; res_next folds the current slice into the
  // partial result so the final edge can publish the complete difference.
  always_comb begin
    a_slice   = a_reg[k*SLICE +: SLICE];
    b_slice   = b_reg[k*SLICE +: SLICE];
    slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE{1'b0}}, carry};
    res_next  = res;
    res_next[k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      res   <= '0;
      done  <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_reg <= A;
          b_reg <= B;
          carry <= ~Bin;
          k     <= '0;
          state <= RUN;
        end
      end else begin
        res   <= res_next;
        carry <= slice_sum[SLICE];
        if (k == K_LAST) begin
          // Outputs only move here, so partial results never leak out.
          D     <= res_next;
          Bout  <= ~slice_sum[SLICE];
          Ovf   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                   (res_next[WIDTH-1] != a_reg[WIDTH-1]);
          done  <= 1'b1;
          k     <= '0;
          state <= IDLE;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule
